// File: rtl/clock_divgen_pkg.sv
// Shared types and helpers for the multi-output clock divider / enable generator.
package clock_divgen_pkg;

  typedef enum logic [1:0] {
    REALIGN = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  // Phase is clamped against the already-clamped divide ratio.
  function automatic int unsigned clamp_phase(input int unsigned phase, input int unsigned div);
    return (phase > div - 1) ? div - 1 : phase;
  endfunction

endpackage

// File: rtl/clock_divgen_chan.sv
// One divider channel: holds div/phase, runs the wrap counter and reports the
// ideal (ungated) clock level and enable strobe for the next cycle.
module clock_divgen_chan
  import clock_divgen_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_phase,
  output logic             ideal_clk,
  output logic             ideal_en
);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [DIV_W-1:0] phase_reg, phase_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;

  always_comb begin
    div_next   = div_reg;
    phase_next = phase_reg;
    if (wr_en) begin
      div_next   = DIV_W'(clamp_div(32'(wr_div)));
      phase_next = DIV_W'(clamp_phase(32'(wr_phase), 32'(div_next)));
    end
    // Loading (div - phase) mod div puts the first zero phase cycles later.
    if (load) begin
      cnt_next = (phase_next == '0) ? '0 : div_next - phase_next;
    end else if (cnt_reg >= div_reg - DIV_W'(1)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + DIV_W'(1);
    end
  end

  assign ideal_clk = (cnt_next < (div_next >> 1));
  assign ideal_en  = (cnt_next == '0);

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      div_reg   <= DIV_W'(DEFAULT_DIV);
      phase_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      div_reg   <= div_next;
      phase_reg <= phase_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/clock_divgen_multi.sv
// Multi-output runtime-reconfigurable clock divider: realign/lock FSM, config
// handshake, per-channel dividers and registered, lock-gated outputs.
module clock_divgen_multi
  import clock_divgen_pkg::*;
#(
  parameter int NUM_CLOCKS  = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2,
  localparam int CHAN_W     = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]      cfg_div,
  input  logic [DIV_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic                  locked
);

  localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) + 1 : 1;

  state_t                  state_reg, state_next;
  logic [LOCK_W-1:0]       lock_cnt_reg, lock_cnt_next;
  logic                    armed_reg;
  logic                    transfer;
  logic                    realign_load;
  logic [NUM_CLOCKS-1:0]   wr_en;
  logic [NUM_CLOCKS-1:0]   ideal_clk, ideal_en;
  logic [NUM_CLOCKS-1:0]   outclk_reg, outclk_en_reg;
  logic                    locked_reg, cfg_ready_reg;

  assign transfer     = cfg_valid && (state_reg == LOCKED);
  assign realign_load = (state_next == REALIGN);

  // The cycle in which rst releases is partial; the full REALIGN cycle is the
  // one following the first edge after release.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    case (state_reg)
      REALIGN: begin
        lock_cnt_next = '0;
        if (armed_reg) state_next = LOCKING;
      end
      LOCKING: begin
        lock_cnt_next = lock_cnt_reg + LOCK_W'(1);
        if (lock_cnt_reg == LOCK_W'(LOCK_CYCLES - 1)) state_next = LOCKED;
      end
      LOCKED: begin
        if (transfer) state_next = REALIGN;
      end
      default: state_next = REALIGN;
    endcase
  end

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
    assign wr_en[gi] = transfer && (cfg_chan == CHAN_W'(gi));

    clock_divgen_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .refclk    (refclk),
      .rst       (rst),
      .load      (realign_load),
      .wr_en     (wr_en[gi]),
      .wr_div    (cfg_div),
      .wr_phase  (cfg_phase),
      .ideal_clk (ideal_clk[gi]),
      .ideal_en  (ideal_en[gi])
    );
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_reg     <= REALIGN;
      lock_cnt_reg  <= '0;
      armed_reg     <= 1'b0;
      outclk_reg    <= '0;
      outclk_en_reg <= '0;
      locked_reg    <= 1'b0;
      cfg_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      armed_reg     <= 1'b1;
      outclk_reg    <= (state_next == LOCKED) ? ideal_clk : '0;
      outclk_en_reg <= (state_next == LOCKED) ? ideal_en : '0;
      locked_reg    <= (state_next == LOCKED);
      cfg_ready_reg <= (state_next == LOCKED);
    end
  end

  assign outclk    = outclk_reg;
  assign outclk_en = outclk_en_reg;
  assign locked    = locked_reg;
  assign cfg_ready = cfg_ready_reg;

endmodule

// File: tb/tb_clock_divgen_multi.sv
// Scoreboard bench: stimulus pushes one expected output vector per cycle,
// a negedge monitor pops and compares against a 4-channel and a 3-channel DUT.
module tb_clock_divgen_multi;

  localparam int LOCK_CYCLES = 16;

  logic       refclk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_div = '0;
  logic [7:0] cfg_phase = '0;
  logic       cfg_ready, locked;
  logic [3:0] outclk, outclk_en;
  logic       cfg_ready_b, locked_b;
  logic [2:0] outclk_b, outclk_en_b;

  always #5 refclk = ~refclk;

  clock_divgen_multi #(
    .NUM_CLOCKS(4), .DIV_W(8), .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_DIV(2)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  // Three channels: cfg_chan == 3 is out of range for this instance.
  clock_divgen_multi #(
    .NUM_CLOCKS(3), .DIV_W(8), .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_DIV(2)
  ) dut_b (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk_b), .outclk_en(outclk_en_b), .locked(locked_b)
  );

  typedef struct {
    int         cyc;
    logic       lock;
    logic [3:0] clk;
    logic [3:0] en;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k = -1;               // cycles since the REALIGN cycle; -1 = reset/release cycle
  int mdiv[4];
  int mph[4];
  logic prev_rst = 1'b1;
  logic prev_v = 1'b0;
  int prev_ch = 0, prev_d = 0, prev_p = 0;

  task automatic set_defaults();
    for (int i = 0; i < 4; i++) begin
      mdiv[i] = 2;
      mph[i]  = 0;
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    int   c;
    e.cyc  = cyc;
    e.lock = (k >= LOCK_CYCLES + 1);
    e.clk  = '0;
    e.en   = '0;
    if (e.lock) begin
      for (int i = 0; i < 4; i++) begin
        c = (((k - mph[i]) % mdiv[i]) + mdiv[i]) % mdiv[i];
        e.clk[i] = (c < mdiv[i] / 2);
        e.en[i]  = (c == 0);
      end
    end
    return e;
  endfunction

  // One cycle: account for the edge just taken, drive next inputs, push expectation.
  task automatic step(input logic r, input logic v, input int ch, input int d, input int p);
    @(posedge refclk);
    #1;
    cyc++;
    if (!prev_rst) begin
      if (prev_v && k >= LOCK_CYCLES + 1) begin
        if (prev_ch < 4) begin
          mdiv[prev_ch] = (prev_d < 2) ? 2 : prev_d;
          mph[prev_ch]  = (prev_p > mdiv[prev_ch] - 1) ? mdiv[prev_ch] - 1 : prev_p;
        end
        k = 0;
      end else begin
        k++;
      end
    end
    rst       = r;
    cfg_valid = v;
    cfg_chan  = 2'(ch);
    cfg_div   = 8'(d);
    cfg_phase = 8'(p);
    if (r) begin
      k = -1;
      set_defaults();
    end
    prev_rst = r;
    prev_v   = v;
    prev_ch  = ch;
    prev_d   = d;
    prev_p   = p;
    #1;
    exp_q.push_back(model_exp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int c, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  always @(negedge refclk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("locked",      mon_e.cyc, {3'b0, locked},      {3'b0, mon_e.lock});
      chk("cfg_ready",   mon_e.cyc, {3'b0, cfg_ready},   {3'b0, mon_e.lock});
      chk("outclk",      mon_e.cyc, outclk,              mon_e.clk);
      chk("outclk_en",   mon_e.cyc, outclk_en,           mon_e.en);
      chk("locked_b",    mon_e.cyc, {3'b0, locked_b},    {3'b0, mon_e.lock});
      chk("cfg_ready_b", mon_e.cyc, {3'b0, cfg_ready_b}, {3'b0, mon_e.lock});
      chk("outclk_b",    mon_e.cyc, {1'b0, outclk_b},    {1'b0, mon_e.clk[2:0]});
      chk("outclk_en_b", mon_e.cyc, {1'b0, outclk_en_b}, {1'b0, mon_e.en[2:0]});
    end
  end

  initial begin
    set_defaults();
    #2 rst = 1'b1;
    // Reset state, then release with defaults: lock on edge 18, div-2 toggling.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0);
    idle(30);
    // chan 1: div 5, phase 2.
    step(1'b0, 1'b1, 1, 5, 2);
    idle(40);
    // Clamping: div 1 -> 2, phase 9 -> 1.
    step(1'b0, 1'b1, 0, 1, 9);
    idle(30);
    // chan 3: real channel on the 4-channel DUT, out of range on the 3-channel one.
    step(1'b0, 1'b1, 3, 7, 3);
    idle(30);
    // cfg_valid held from reset release: exactly one transfer on the first LOCKED cycle.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b1, 2, 3, 1);
    idle(25);
    // Write, then reset 3 cycles into LOCKING: defaults restored and relock.
    step(1'b0, 1'b1, 1, 4, 3);
    idle(4);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 0, 0, 0);
    idle(25);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge refclk);
    @(posedge refclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
